controle_enchimento: RTL and testbench
======================================

// Module: controle_enchimento
// PURPOSE
// - Sequential inlet-valve / alarm controller; sits directly downstream of the level decoder.
// - Consumes its combinational outputs: Ve, Al, ERRO and the level flags Nv_Critico, Nv_Baixo, Nv_Medio, Nv_Alto.
// - Drives the physical inlet valve and the alarm.
// - Adds what the decoder lacks: input registering, minimum valve on-time, post-full hold-off, fill timeout and a persistent-error filter with a sticky fault.
// PARAMETERS
// - CNT_W        16  width of all internal counters; every count parameter must be < 2**CNT_W.
// - MIN_ON       4   minimum cycles valve stays open once FILLING is entered (>=1).
// - FILL_TIMEOUT 20  max cycles in FILLING without Nv_Alto before timeout FAULT (> MIN_ON).
// - HOLD         3   cycles valve stays closed in FULL before returning to IDLE (>=1).
// - ERR_PERSIST  3   consecutive cycles ERRO must be high to enter FAULT (>=1).
// - BLINK_HALF   2   alarm half-period in cycles; used only with ALARM_BLINK_EN (>=1).
// PORTS
// - clk         in   1  system clock, rising edge.
// - rst         in   1  synchronous, active-high reset.
// - Ve          in   1  decoder fill request.
// - Al          in   1  decoder alarm request.
// - ERRO        in   1  decoder invalid-probe flag.
// - Nv_Alto     in   1  decoder full flag.
// - Nv_Critico  in   1  decoder critical flag; forces alarm.
// - fault_clr   in   1  single-cycle request to leave FAULT.
// - valve_open  out  1  inlet valve drive.
// - alarm_out   out  1  alarm drive.
// - fault       out  1  sticky fault indicator.
// - state       out  2  FSM state: IDLE=0, FILLING=1, FULL=2, FAULT=3.
// BEHAVIOUR
// - Inputs: Ve, Al, ERRO, Nv_Alto, Nv_Critico are registered once (_r) every cycle; the FSM uses only _r.
// - Outputs: decoded from registered state/flags, glitch-free.
// - Reset: all input registers and counters = 0; state = IDLE; valve_open = 0; alarm_out = 0; fault = 0.
// - Reset mid-FILLING closes the valve on the next edge.
// - err_cnt: increments while ERRO_r = 1, saturates at ERR_PERSIST, clears to 0 on any cycle ERRO_r = 0.
// - Error priority: err_cnt == ERR_PERSIST -> FAULT from any state; overrides every other transition in that cycle.
// - IDLE:
//   - valve_open = 0.
//   - Ve_r = 1 -> FILLING; fill_cnt <= 0.
// - FILLING:
//   - valve_open = 1; fill_cnt += 1 each cycle.
//   - Nv_Alto_r = 1 -> FULL (immediately, even before MIN_ON); hold_cnt <= 0.
//   - Else Ve_r = 0 and fill_cnt >= MIN_ON-1 -> IDLE.
//   - Else fill_cnt == FILL_TIMEOUT-1 -> FAULT.
// - FULL:
//   - valve_open = 0; hold_cnt += 1.
//   - hold_cnt == HOLD-1 -> IDLE. Ve_r is ignored until then (anti-chatter).
// - FAULT:
//   - valve_open = 0; fault = 1.
//   - Exit to IDLE only when fault_clr = 1 and err_cnt == 0 in the same cycle.
//   - fault_clr outside FAULT: no effect.
// - Latency: input change at edge k -> captured at k -> state/valve update at edge k+1. Two edges from pin to valve.
// - Alarm request: Al_r | Nv_Critico_r | (state == FAULT).
// - Counters never wrap: fill_cnt is bounded by timeout, hold_cnt by HOLD.
// CONFIGURATION
// - Macro ALARM_BLINK_EN defined:
//   - While the alarm request is high, alarm_out toggles every BLINK_HALF cycles, starting with an ON phase.
//   - blink_cnt and phase reset whenever the request is low; alarm_out = 0 then.
// - Macro ALARM_BLINK_EN undefined:
//   - alarm_out = alarm request, registered, steady.
//   - No blink counter is instantiated.
// TESTING (defaults as listed above)
// - Reset: rst high 2 cycles with all inputs high -> after release, state = 0, valve_open = 0, fault = 0.
// - Normal fill:
//   - Ve = 1 from cycle 0 -> valve_open = 1 after edge 1.
//   - Nv_Alto = 1, Ve = 0 at cycle 8 -> state = FULL and valve_open = 0 after edge 9.
//   - IDLE after 3 further cycles.
// - Min on-time: Ve pulses high 1 cycle only -> valve_open stays high exactly 4 cycles, then IDLE.
// - Timeout: Ve = 1, Nv_Alto never set -> FAULT after 20 cycles in FILLING.
//   - fault = 1, valve_open = 0, alarm_out = 1.
//   - fault_clr with ERRO = 0 -> IDLE.
// - Error filter:
//   - ERRO high 2 cycles, low, high 2 cycles -> no FAULT.
//   - ERRO high 3 consecutive cycles -> FAULT.
//   - fault_clr while ERRO still high -> remains FAULT.
// - Alarm (ALARM_BLINK_EN): Al held high 10 cycles -> alarm_out pattern 1,1,0,0,1,1,0,0,1,1.
//   - Without the macro: steady 1.

Source files
------------

// File: rtl/controle_enchimento_if.sv
// rtl/controle_enchimento_if.sv - decoder flags in, valve/alarm/fault drives out
interface controle_enchimento_if;
    logic       Ve;
    logic       Al;
    logic       ERRO;
    logic       Nv_Alto;
    logic       Nv_Critico;
    logic       fault_clr;
    logic       valve_open;
    logic       alarm_out;
    logic       fault;
    logic [1:0] state;

    modport master (
        output Ve, Al, ERRO, Nv_Alto, Nv_Critico, fault_clr,
        input  valve_open, alarm_out, fault, state
    );

    modport slave (
        input  Ve, Al, ERRO, Nv_Alto, Nv_Critico, fault_clr,
        output valve_open, alarm_out, fault, state
    );
endinterface

// File: rtl/controle_enchimento.sv
// rtl/controle_enchimento.sv - inlet valve / alarm FSM with min on-time, hold-off, timeout and error filter
// Optional blinking alarm selected by macro ALARM_BLINK_EN.
module controle_enchimento #(
    parameter int CNT_W        = 16,
    parameter int MIN_ON       = 4,
    parameter int FILL_TIMEOUT = 20,
    parameter int HOLD         = 3,
    parameter int ERR_PERSIST  = 3
`ifdef ALARM_BLINK_EN
    ,
    parameter int BLINK_HALF   = 2
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    controle_enchimento_if.slave  bus
);

    localparam logic [CNT_W-1:0] ONE          = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_ON_LAST  = CNT_W'(MIN_ON - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(FILL_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] ERR_MAX      = CNT_W'(ERR_PERSIST);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2,
        FAULT   = 2'd3
    } state_t;

    state_t           state_q;
    logic             ve_r, al_r, erro_r, nv_alto_r, nv_critico_r;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] fill_cnt;
    logic [CNT_W-1:0] hold_cnt;
    logic             valve_q;
    logic             fault_q;
    logic             alarm_q;
    logic             alarm_req;

    // Decoder outputs are combinational; register them once so the FSM sees clean levels.
    always_ff @(posedge clk) begin
        if (rst) begin
            ve_r         <= 1'b0;
            al_r         <= 1'b0;
            erro_r       <= 1'b0;
            nv_alto_r    <= 1'b0;
            nv_critico_r <= 1'b0;
            err_cnt      <= '0;
        end else begin
            ve_r         <= bus.Ve;
            al_r         <= bus.Al;
            erro_r       <= bus.ERRO;
            nv_alto_r    <= bus.Nv_Alto;
            nv_critico_r <= bus.Nv_Critico;
            if (!erro_r)
                err_cnt <= '0;
            else if (err_cnt != ERR_MAX)
                err_cnt <= err_cnt + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            fill_cnt <= '0;
            hold_cnt <= '0;
            valve_q  <= 1'b0;
            fault_q  <= 1'b0;
        end else if (err_cnt == ERR_MAX) begin
            // Persistent probe error wins over every other transition.
            state_q <= FAULT;
            valve_q <= 1'b0;
            fault_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ve_r) begin
                        state_q  <= FILLING;
                        fill_cnt <= '0;
                        valve_q  <= 1'b1;
                    end
                end
                FILLING: begin
                    fill_cnt <= fill_cnt + ONE;
                    if (nv_alto_r) begin
                        state_q  <= FULL;
                        hold_cnt <= '0;
                        valve_q  <= 1'b0;
                    end else if (!ve_r && (fill_cnt >= MIN_ON_LAST)) begin
                        state_q <= IDLE;
                        valve_q <= 1'b0;
                    end else if (fill_cnt == TIMEOUT_LAST) begin
                        state_q <= FAULT;
                        valve_q <= 1'b0;
                        fault_q <= 1'b1;
                    end
                end
                FULL: begin
                    // Fill requests are ignored until the hold-off expires.
                    hold_cnt <= hold_cnt + ONE;
                    if (hold_cnt == HOLD_LAST)
                        state_q <= IDLE;
                end
                FAULT: begin
                    if (bus.fault_clr && (err_cnt == '0)) begin
                        state_q <= IDLE;
                        fault_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign alarm_req = al_r | nv_critico_r | (state_q == FAULT);

`ifdef ALARM_BLINK_EN
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_HALF - 1);

    logic [CNT_W-1:0] blink_cnt;
    logic             blink_off;

    // A fresh request always starts with an ON half-period.
    always_ff @(posedge clk) begin
        if (rst || !alarm_req) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            alarm_q <= !blink_off;
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                blink_off <= !blink_off;
            end else begin
                blink_cnt <= blink_cnt + ONE;
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst)
            alarm_q <= 1'b0;
        else
            alarm_q <= alarm_req;
    end
`endif

    assign bus.valve_open = valve_q;
    assign bus.alarm_out  = alarm_q;
    assign bus.fault      = fault_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_controle_enchimento.sv
// tb/tb_controle_enchimento.sv - table-driven scoreboard bench for controle_enchimento
module tb_controle_enchimento;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    controle_enchimento_if bus();

    controle_enchimento dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string      tag;
        logic       rst, ve, al, erro, alto, crit, clr;
        int         n;
        logic       ev, ea, ef;
        logic [1:0] es;
        bit         ca;
    } vec_t;

    typedef struct {
        string      tag;
        logic       ev, ea, ef;
        logic [1:0] es;
        bit         ca;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic [9:0] pat;

    function automatic vec_t mk(string tag, logic r, logic ve, logic al, logic erro,
                                logic alto, logic crit, logic clr, int n,
                                logic ev, logic ea, logic ef, logic [1:0] es, bit ca);
        vec_t v;
        v.tag = tag; v.rst = r; v.ve = ve; v.al = al; v.erro = erro;
        v.alto = alto; v.crit = crit; v.clr = clr; v.n = n;
        v.ev = ev; v.ea = ea; v.ef = ef; v.es = es; v.ca = ca;
        return v;
    endfunction

    function automatic void add(string tag, logic r, logic ve, logic al, logic erro,
                                logic alto, logic crit, logic clr, int n,
                                logic ev, logic ea, logic ef, logic [1:0] es, bit ca);
        tbl.push_back(mk(tag, r, ve, al, erro, alto, crit, clr, n, ev, ea, ef, es, ca));
    endfunction

    task automatic check(input exp_t e);
        n_vec++;
        if (bus.valve_open !== e.ev) begin
            n_err++;
            $display("FAIL %s valve_open: got %b want %b", e.tag, bus.valve_open, e.ev);
        end
        if (bus.fault !== e.ef) begin
            n_err++;
            $display("FAIL %s fault: got %b want %b", e.tag, bus.fault, e.ef);
        end
        if (bus.state !== e.es) begin
            n_err++;
            $display("FAIL %s state: got %0d want %0d", e.tag, bus.state, e.es);
        end
        if (e.ca && (bus.alarm_out !== e.ea)) begin
            n_err++;
            $display("FAIL %s alarm_out: got %b want %b", e.tag, bus.alarm_out, e.ea);
        end
    endtask

    task automatic step(input vec_t v, input bit chk);
        exp_t e;
        @(negedge clk);
        rst           = v.rst;
        bus.Ve        = v.ve;
        bus.Al        = v.al;
        bus.ERRO      = v.erro;
        bus.Nv_Alto   = v.alto;
        bus.Nv_Critico = v.crit;
        bus.fault_clr = v.clr;
        if (chk) begin
            e.tag = v.tag; e.ev = v.ev; e.ea = v.ea; e.ef = v.ef; e.es = v.es; e.ca = v.ca;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check(e);
        end
    endtask

    task automatic apply(input vec_t v);
        for (int i = 0; i < v.n; i++)
            step(v, i == v.n - 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, summary not reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.Ve = 1'b0; bus.Al = 1'b0; bus.ERRO = 1'b0;
        bus.Nv_Alto = 1'b0; bus.Nv_Critico = 1'b0; bus.fault_clr = 1'b0;

        //   tag            rst ve al er hi cr clr  n   valve alarm fault state chk_alarm
        add("rst_hold",      1, 1, 1, 1, 1, 1, 1,  2,  0, 0, 0, 2'd0, 1);
        add("rst_release",   0, 0, 0, 0, 0, 0, 0,  1,  0, 0, 0, 2'd0, 1);
        add("fill_capture",  0, 1, 0, 0, 0, 0, 0,  1,  0, 0, 0, 2'd0, 1);
        add("fill_open",     0, 1, 0, 0, 0, 0, 0,  1,  1, 0, 0, 2'd1, 1);
        add("fill_run",      0, 1, 0, 0, 0, 0, 0,  6,  1, 0, 0, 2'd1, 1);
        add("alto_capture",  0, 0, 0, 0, 1, 0, 0,  1,  1, 0, 0, 2'd1, 1);
        add("full_enter",    0, 0, 0, 0, 1, 0, 0,  1,  0, 0, 0, 2'd2, 1);
        add("full_ignore_ve",0, 1, 0, 0, 1, 0, 0,  2,  0, 0, 0, 2'd2, 1);
        add("full_to_idle",  0, 0, 0, 0, 0, 0, 0,  1,  0, 0, 0, 2'd0, 1);
        add("clr_in_idle",   0, 0, 0, 0, 0, 0, 1,  2,  0, 0, 0, 2'd0, 1);
        add("pulse",         0, 1, 0, 0, 0, 0, 0,  1,  0, 0, 0, 2'd0, 1);
        add("min_on_1",      0, 0, 0, 0, 0, 0, 0,  1,  1, 0, 0, 2'd1, 1);
        add("min_on_2",      0, 0, 0, 0, 0, 0, 0,  1,  1, 0, 0, 2'd1, 1);
        add("min_on_3",      0, 0, 0, 0, 0, 0, 0,  1,  1, 0, 0, 2'd1, 1);
        add("min_on_4",      0, 0, 0, 0, 0, 0, 0,  1,  1, 0, 0, 2'd1, 1);
        add("min_on_end",    0, 0, 0, 0, 0, 0, 0,  1,  0, 0, 0, 2'd0, 1);
        add("to_capture",    0, 1, 0, 0, 0, 0, 0,  1,  0, 0, 0, 2'd0, 1);
        add("to_fill20",     0, 1, 0, 0, 0, 0, 0, 20,  1, 0, 0, 2'd1, 1);
        add("to_fault",      0, 1, 0, 0, 0, 0, 0,  1,  0, 0, 1, 2'd3, 1);
        add("to_alarm",      0, 0, 0, 0, 0, 0, 0,  1,  0, 1, 1, 2'd3, 1);
        add("to_clear",      0, 0, 0, 0, 0, 0, 1,  1,  0, 1, 0, 2'd0, 1);
        add("to_quiet",      0, 0, 0, 0, 0, 0, 0,  1,  0, 0, 0, 2'd0, 1);
        add("err_2a",        0, 0, 0, 1, 0, 0, 0,  2,  0, 0, 0, 2'd0, 1);
        add("err_gap",       0, 0, 0, 0, 0, 0, 0,  1,  0, 0, 0, 2'd0, 1);
        add("err_2b",        0, 0, 0, 1, 0, 0, 0,  2,  0, 0, 0, 2'd0, 1);
        add("err_gap2",      0, 0, 0, 0, 0, 0, 0,  4,  0, 0, 0, 2'd0, 1);
        add("err_3",         0, 0, 0, 1, 0, 0, 0,  3,  0, 0, 0, 2'd0, 1);
        add("err_count",     0, 0, 0, 0, 0, 0, 0,  1,  0, 0, 0, 2'd0, 1);
        add("err_fault",     0, 0, 0, 1, 0, 0, 0,  1,  0, 0, 1, 2'd3, 1);
        add("err_hold",      0, 0, 0, 1, 0, 0, 0,  1,  0, 1, 1, 2'd3, 1);
        add("clr_erro_high", 0, 0, 0, 1, 0, 0, 1,  1,  0, 1, 1, 2'd3, 1);
        add("err_drain",     0, 0, 0, 0, 0, 0, 0,  3,  0, 0, 1, 2'd3, 0);
        add("clr_ok",        0, 0, 0, 0, 0, 0, 1,  1,  0, 0, 0, 2'd0, 0);
        add("clr_quiet",     0, 0, 0, 0, 0, 0, 0,  1,  0, 0, 0, 2'd0, 1);
        add("crit_capture",  0, 0, 0, 0, 0, 1, 0,  1,  0, 0, 0, 2'd0, 1);
        add("crit_alarm",    0, 0, 0, 0, 0, 0, 0,  1,  0, 1, 0, 2'd0, 1);
        add("crit_gone",     0, 0, 0, 0, 0, 0, 0,  1,  0, 0, 0, 2'd0, 1);

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i]);

        // Reset while filling must close the valve on that same edge.
        step(mk("rm_capture", 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'd0, 1), 1'b1);
        step(mk("rm_open",    0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2'd1, 1), 1'b1);
        step(mk("rm_reset",   1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'd0, 1), 1'b1);
        step(mk("rm_after",   0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'd0, 1), 1'b1);

`ifdef ALARM_BLINK_EN
        pat = 10'b1100110011;
`else
        pat = 10'b1111111111;
`endif
        step(mk("al_capture", 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 2'd0, 1), 1'b1);
        for (int i = 0; i < 10; i++)
            step(mk($sformatf("al_cycle%0d", i), 0, 0, (i < 9) ? 1'b1 : 1'b0, 0, 0, 0, 0, 1,
                    0, pat[9-i], 0, 2'd0, 1), 1'b1);
        step(mk("al_off", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'd0, 1), 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
